snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//  Consumes the one-cycle debounced key pulses (X0_deb..X3_deb) and turns them into the snake's
//  heading. Queues up to two pending turns, rejects 180-degree reversals, and applies at most one
//  turn per move step. Generates the periodic move_tick that paces the snake-body/VGA logic.
// PARAMETERS
//  TICK_W  22        width of move-period counter
//  PERIOD  2500000   VGA_CLK cycles per move step (2..2**TICK_W); ~10 steps/s at 25 MHz
// PORTS
//  VGA_CLK   in   1       single clock; all state on posedge
//  reset     in   1       asynchronous, active-low reset (0 = reset)
//  X0_deb    in   1       one-cycle "up" key pulse
//  X1_deb    in   1       one-cycle "down" key pulse
//  X2_deb    in   1       one-cycle "left" key pulse
//  X3_deb    in   1       one-cycle "right" key pulse
//  run       in   1       1 = game running (counter advances); 0 = paused
//  restart   in   1       sync pulse: return to reset state without asserting reset
//  dir       out  2       current heading: UP=00 DOWN=01 LEFT=10 RIGHT=11
//  move_tick out  1       one-cycle pulse per move step; dir is valid for that step in the same cycle
//  key_drop  out  1       one-cycle pulse when an accepted-direction key is lost because queue is full
// BEHAVIOUR
//  Reset (reset=0, async) or restart=1 (sync, highest priority): dir=RIGHT, queue empty, cnt=0,
//   move_tick=0, key_drop=0. Keys in a restart cycle are ignored.
//  Key decode: exactly one Xn_deb high = request with encoded dir; zero or >1 high = no request.
//  Reference heading R = queue tail if non-empty, else dir (tail-of-queue after any same-cycle pop).
//  Request k accepted iff k != R and k != R^2'b01 (opposite = bit0 flipped). Rejected = silently ignored.
//  Accepted with queue full (2 entries, no same-cycle pop) -> not stored, key_drop=1 next cycle.
//  Accepted with a pop the same cycle -> push succeeds (pop frees a slot first).
//  Counter: run=1 -> cnt increments; at cnt==PERIOD-1 the edge sets cnt=0, move_tick=1 (registered,
//   high exactly one cycle), and if queue non-empty dir<=head, head popped. run=0 -> cnt holds,
//   no ticks, keys still queued. Wrap is PERIOD-1 -> 0, never reaches PERIOD.
//  Latency: key pulse at cycle t -> queued at edge t+1; earliest dir change at next tick edge.
//  dir changes only on move_tick edges (or reset/restart); at most one turn consumed per tick.
//  Empty queue at tick: dir unchanged, move_tick still asserted.
// STRUCTURE
//  Shared package snake_pkg: DIR_UP/DOWN/LEFT/RIGHT 2-bit localparams, opposite function (bit0 flip),
//   reused by the body/collision logic.
//  Sub-module dir_fifo: 2-entry x 2-bit FIFO, ports push/pop/din/head/tail/count, flush input for restart;
//   simultaneous push+pop at count 2 stays at 2. Top holds counter, decode, accept logic, dir register.
// TESTING (PERIOD=4 in sim)
//  Reset release, no keys, run=1 -> dir=11 constant, move_tick high every 4th cycle, key_drop=0.
//  dir=RIGHT, pulse X2 (left) -> rejected; pulse X1 (down) -> at next tick dir=01.
//  dir=RIGHT, pulses X0 then X2 between ticks -> tick1 dir=00, tick2 dir=10.
//  Queue holds [UP,LEFT], pulse X1 (DOWN, valid vs tail LEFT) not on tick -> key_drop=1 one cycle.
//  X0 and X3 high same cycle -> no enqueue; run=0 for 10 cycles -> no move_tick, cnt held.
//  reset=0 mid-period with queue [DOWN] -> dir=11, queue empty, cnt=0 immediately (no clock edge).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game definitions: heading encodings and the reversal helper.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Opposite headings differ only in bit 0 (UP<->DOWN, LEFT<->RIGHT).
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-deep queue of pending headings; exposes both ends so the caller can
// validate new keys against the most recently queued turn.
module dir_fifo (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [1:0] count
);

    logic [1:0] slot [2];

    // NOTE: the two slots are ordinary flops, so they are reset along with count; this keeps head/tail defined after reset.
    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            slot[0] <= 2'b00;
            slot[1] <= 2'b00;
            count   <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: if (count != 2'd2) begin
                    slot[count[0]] <= din;
                    count          <= count + 2'd1;
                end
                2'b01: if (count != 2'd0) begin
                    slot[0] <= slot[1];
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    // The pop frees a slot first, so a push always lands.
                    if (count == 2'd2) begin
                        slot[0] <= slot[1];
                        slot[1] <= din;
                    end else begin
                        slot[0] <= din;
                        count   <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = slot[0];
    assign tail = (count == 2'd2) ? slot[1] : slot[0];

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced key pulses into the snake heading, paced by a periodic
// move_tick; up to two turns are buffered and one is applied per step.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_W = 22,
    parameter int PERIOD = 2500000
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    input  logic       X0_deb,
    input  logic       X1_deb,
    input  logic       X2_deb,
    input  logic       X3_deb,
    input  logic       run,
    input  logic       restart,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       key_drop
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(PERIOD - 1);

    logic [TICK_W-1:0] cnt;
    logic [3:0]        keys;
    logic              req_valid;
    logic [1:0]        req_dir;
    logic [1:0]        ref_dir;
    logic              tick_now;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic [1:0]        q_head;
    logic [1:0]        q_tail;
    logic [1:0]        q_count;

    assign keys = {X3_deb, X2_deb, X1_deb, X0_deb};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        case (keys)
            4'b0001: req_dir = DIR_UP;
            4'b0010: req_dir = DIR_DOWN;
            4'b0100: req_dir = DIR_LEFT;
            4'b1000: req_dir = DIR_RIGHT;
            default: req_valid = 1'b0;
        endcase
    end

    // A same-cycle pop leaves the queue tail (or, if it empties, the new
    // heading) equal to the old tail, so the pre-pop tail is the reference.
    always_comb begin
        ref_dir  = (q_count != 2'd0) ? q_tail : dir;
        tick_now = run && (cnt == LAST);
        pop      = tick_now && (q_count != 2'd0);
        accept   = req_valid && !restart
                   && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
        push     = accept && ((q_count != 2'd2) || pop);
        drop     = accept && !push;
    end

    dir_fifo u_fifo (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .flush   (restart),
        .push    (push),
        .pop     (pop),
        .din     (req_dir),
        .head    (q_head),
        .tail    (q_tail),
        .count   (q_count)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            dir       <= DIR_RIGHT;
            cnt       <= '0;
            move_tick <= 1'b0;
            key_drop  <= 1'b0;
        end else if (restart) begin
            dir       <= DIR_RIGHT;
            cnt       <= '0;
            move_tick <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            move_tick <= tick_now;
            key_drop  <= drop;
            if (run) cnt <= tick_now ? '0 : cnt + TICK_W'(1);
            if (pop) dir <= q_head;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed plus randomized bench for snake_dir_ctrl, checked against a
// queue-based model of the turn rules (PERIOD=4).
module tb_snake_dir_ctrl;

    localparam int PERIOD = 4;

    logic       VGA_CLK = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] keys    = 4'b0000;
    logic       run     = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] dir;
    logic       move_tick;
    logic       key_drop;

    always #5 VGA_CLK = ~VGA_CLK;

    snake_dir_ctrl #(.TICK_W(3), .PERIOD(PERIOD)) dut (
        .VGA_CLK   (VGA_CLK),
        .reset     (reset),
        .X0_deb    (keys[0]),
        .X1_deb    (keys[1]),
        .X2_deb    (keys[2]),
        .X3_deb    (keys[3]),
        .run       (run),
        .restart   (restart),
        .dir       (dir),
        .move_tick (move_tick),
        .key_drop  (key_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;

    // Reference model: heading, pending-turn queue, step counter, expected pulses.
    logic [1:0] m_dir;
    logic [1:0] m_q[$];
    int         m_cnt;
    logic       m_tick;
    logic       m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_dir  = 2'b11;
        m_q.delete();
        m_cnt  = 0;
        m_tick = 1'b0;
        m_drop = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] k, input logic r, input logic rs);
        logic [1:0] nd;
        logic [1:0] ref_h;
        int hot;
        int idx;
        if (rs) begin
            model_reset();
            return;
        end
        m_tick = r && (m_cnt == PERIOD - 1);
        nd = m_dir;
        if (m_tick && m_q.size() > 0) nd = m_q.pop_front();
        m_drop = 1'b0;
        hot = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (k[i]) begin hot++; idx = i; end
        if (hot == 1) begin
            ref_h = (m_q.size() > 0) ? m_q[m_q.size() - 1] : nd;
            if (2'(idx) != ref_h && 2'(idx) != (ref_h ^ 2'b01)) begin
                if (m_q.size() < 2) m_q.push_back(2'(idx));
                else m_drop = 1'b1;
            end
        end
        if (r) m_cnt = m_tick ? 0 : m_cnt + 1;
        m_dir = nd;
    endfunction

    task automatic step(input logic [3:0] k, input logic r, input logic rs, input string tag);
        keys    = k;
        run     = r;
        restart = rs;
        @(posedge VGA_CLK);
        if (!reset) model_reset();
        else model_edge(k, r, rs);
        #1;
        if (move_tick) n_ticks++;
        check({tag, ".dir"}, 32'(dir), 32'(m_dir));
        check({tag, ".tick"}, 32'(move_tick), 32'(m_tick));
        check({tag, ".drop"}, 32'(key_drop), 32'(m_drop));
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 2 * PERIOD + 2; i++) begin
            step(4'b0000, 1'b1, 1'b0, tag);
            if (m_tick) return;
        end
        n_checks++;
        n_errors++;
        $error("FAIL %s: move_tick not seen within budget", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [3:0] rk;
        int sel;

        // Reset state while reset is held.
        #12;
        check("reset.dir", 32'(dir), 32'h3);
        check("reset.tick", 32'(move_tick), 32'h0);
        check("reset.drop", 32'(key_drop), 32'h0);
        model_reset();
        @(negedge VGA_CLK);
        reset = 1'b1;

        // Idle: RIGHT held, one tick every PERIOD cycles.
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1, 1'b0, "idle");
        check("idle.ticks", 32'(n_ticks), 32'd3);

        // LEFT rejected as reversal, DOWN accepted and applied at the tick.
        step(4'b0100, 1'b1, 1'b0, "s2.left");
        step(4'b0000, 1'b1, 1'b0, "s2.gap");
        check("s2.dir_hold", 32'(dir), 32'h3);
        step(4'b0010, 1'b1, 1'b0, "s2.down");
        step(4'b0000, 1'b1, 1'b0, "s2.tick");
        check("s2.tick_seen", 32'(move_tick), 32'h1);
        check("s2.dir_down", 32'(dir), 32'h1);

        // Two queued turns consumed one per tick.
        step(4'b0000, 1'b1, 1'b1, "s3.restart");
        check("s3.restart_dir", 32'(dir), 32'h3);
        step(4'b0001, 1'b1, 1'b0, "s3.up");
        step(4'b0100, 1'b1, 1'b0, "s3.left");
        wait_tick("s3.t1");
        check("s3.dir_up", 32'(dir), 32'h0);
        wait_tick("s3.t2");
        check("s3.dir_left", 32'(dir), 32'h2);

        // Queue full: third valid key is dropped and flagged for one cycle.
        step(4'b0001, 1'b1, 1'b0, "s4.up");
        step(4'b0100, 1'b1, 1'b0, "s4.left");
        step(4'b0010, 1'b1, 1'b0, "s4.down");
        check("s4.drop_hi", 32'(key_drop), 32'h1);
        step(4'b0000, 1'b1, 1'b0, "s4.tick");
        check("s4.drop_lo", 32'(key_drop), 32'h0);
        check("s4.dir_up", 32'(dir), 32'h0);
        wait_tick("s4.t2");
        check("s4.dir_left", 32'(dir), 32'h2);

        // Two keys at once is no request; pause freezes the counter.
        step(4'b1001, 1'b1, 1'b0, "s5.multi");
        wait_tick("s5.t1");
        check("s5.dir_keep", 32'(dir), 32'h2);
        snap = n_ticks;
        for (int i = 0; i < 10; i++)
            step((i == 4) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, "s5.pause");
        check("s5.no_ticks", 32'(n_ticks - snap), 32'd0);
        wait_tick("s5.resume");
        check("s5.dir_down", 32'(dir), 32'h1);

        // Asynchronous reset mid-period with a queued turn.
        step(4'b0000, 1'b1, 1'b1, "s6.restart");
        step(4'b0010, 1'b1, 1'b0, "s6.down");
        step(4'b0000, 1'b1, 1'b0, "s6.gap");
        #2;
        reset = 1'b0;
        #1;
        check("s6.async_dir", 32'(dir), 32'h3);
        check("s6.async_tick", 32'(move_tick), 32'h0);
        check("s6.async_drop", 32'(key_drop), 32'h0);
        model_reset();
        step(4'b0000, 1'b1, 1'b0, "s6.hold");
        step(4'b0000, 1'b1, 1'b0, "s6.hold");
        reset = 1'b1;
        for (int i = 0; i < PERIOD; i++) step(4'b0000, 1'b1, 1'b0, "s6.post");
        check("s6.post_tick", 32'(move_tick), 32'h1);
        check("s6.post_dir", 32'(dir), 32'h3);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) rk = 4'b0000;
            else if (sel < 9) rk = 4'b0001 << $urandom_range(0, 3);
            else rk = 4'($urandom);
            step(rk, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
